counter_updown_mod: RTL and testbench

Parametrised modulo up/down counter, the successor to the team's plain binary up/down counter. Adds a programmable terminal value, variable step, synchronous clear and load, a wrap-or-saturate mode and a registered overflow/underflow flag. Intended for timer and prescaler chains, and for address generators that need a non-power-of-two range.

---
 rtl/counter_updown_mod.sv | 88 ++++++++
 tb/tb_counter_updown_mod.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// Modulo up/down counter with range 0..MAX, variable step, clear/load and wrap-or-saturate.
// ovf is a registered one-cycle flag marking a count that crossed 0 or MAX.
module counter_updown_mod #(
    parameter int BITS     = 4,
    parameter int MAX      = 2**BITS - 1,
    parameter int SATURATE = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            enable,
    input  logic            up,
    input  logic [BITS-1:0] step,
    output logic [BITS-1:0] q,
    output logic            ovf,
    output logic            at_max,
    output logic            at_min
);

    localparam logic [BITS:0]   MAX_X = (BITS+1)'(MAX);
    localparam logic [BITS:0]   MOD_X = (BITS+1)'(MAX + 1);
    localparam logic [BITS-1:0] MAX_Q = BITS'(MAX);

    if (MAX < 1 || MAX > 2**BITS - 1) begin : g_max_range
        $error("counter_updown_mod: MAX=%0d outside 1..%0d", MAX, 2**BITS - 1);
    end

    logic [BITS-1:0] r_q;
    logic            r_ovf;
    logic [BITS:0]   w_q_x;
    logic [BITS:0]   w_step_x;
    logic [BITS:0]   w_load_x;
    logic [BITS:0]   w_s;
    logic [BITS:0]   w_sum;
    logic [BITS-1:0] w_q_next;
    logic            w_ovf_next;

    // One extra bit of headroom: q + s and q + (MAX+1) - s never exceed 2*MAX.
    assign w_q_x    = {1'b0, r_q};
    assign w_step_x = {1'b0, step};
    assign w_load_x = {1'b0, load_value};
    assign w_s      = (w_step_x > MAX_X) ? MAX_X : w_step_x;
    assign w_sum    = w_q_x + w_s;

    always_comb begin
        w_q_next   = r_q;
        w_ovf_next = 1'b0;
        if (clear) begin
            w_q_next = '0;
        end else if (load) begin
            w_q_next = (w_load_x > MAX_X) ? MAX_Q : load_value;
        end else if (enable) begin
            if (up) begin
                if (w_sum > MAX_X) begin
                    w_ovf_next = 1'b1;
                    w_q_next   = (SATURATE != 0) ? MAX_Q : BITS'(w_sum - MOD_X);
                end else begin
                    w_q_next = BITS'(w_sum);
                end
            end else begin
                if (w_s > w_q_x) begin
                    w_ovf_next = 1'b1;
                    w_q_next   = (SATURATE != 0) ? '0 : BITS'(w_q_x + MOD_X - w_s);
                end else begin
                    w_q_next = BITS'(w_q_x - w_s);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q   <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_ovf <= w_ovf_next;
        end
    end

    assign q      = r_q;
    assign ovf    = r_ovf;
    assign at_max = (r_q == MAX_Q);
    assign at_min = (r_q == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: one wrap-mode and one saturate-mode instance
// (BITS=4, MAX=9) share the same stimulus; expected values are hand-computed.
module tb_counter_updown_mod;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic       up;
    logic [3:0] step;
    logic [3:0] w_q_w, w_q_s;
    logic       w_ovf_w, w_ovf_s;
    logic       w_max_w, w_max_s;
    logic       w_min_w, w_min_s;

    int n_checks = 0;
    int n_errors = 0;

    counter_updown_mod #(.BITS(4), .MAX(9), .SATURATE(0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up(up), .step(step),
        .q(w_q_w), .ovf(w_ovf_w), .at_max(w_max_w), .at_min(w_min_w)
    );

    counter_updown_mod #(.BITS(4), .MAX(9), .SATURATE(1)) u_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load),
        .load_value(load_value), .enable(enable), .up(up), .step(step),
        .q(w_q_s), .ovf(w_ovf_s), .at_max(w_max_s), .at_min(w_min_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic c, input logic l, input logic [3:0] lv,
                       input logic en, input logic u, input logic [3:0] st);
        clear = c; load = l; load_value = lv; enable = en; up = u; step = st;
        tick();
    endtask

    task automatic chk_w(input string tag, input int eq, input int eovf);
        check({tag, "_wq"}, int'(w_q_w), eq);
        check({tag, "_wovf"}, int'(w_ovf_w), eovf);
    endtask

    task automatic chk_s(input string tag, input int eq, input int eovf);
        check({tag, "_sq"}, int'(w_q_s), eq);
        check({tag, "_sovf"}, int'(w_ovf_s), eovf);
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
        enable = 1'b0; up = 1'b1; step = '0;

        // Reset and hold
        #12;
        chk_w("rst", 0, 0);
        check("rst_min", int'(w_min_w), 1);
        check("rst_max", int'(w_max_w), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd(0, 0, 4'd0, 0, 1, 4'd1);
            chk_w("hold", 0, 0);
            check("hold_min", int'(w_min_w), 1);
            check("hold_max", int'(w_max_w), 0);
        end

        // Wrap/saturate, step 1, 11 edges
        for (int i = 1; i <= 11; i++) begin
            cmd(0, 0, 4'd0, 1, 1, 4'd1);
            chk_w("up1", i % 10, (i == 10) ? 1 : 0);
            check("up1_wmax", int'(w_max_w), ((i % 10) == 9) ? 1 : 0);
            check("up1_wmin", int'(w_min_w), ((i % 10) == 0) ? 1 : 0);
            chk_s("up1", (i > 9) ? 9 : i, (i >= 10) ? 1 : 0);
        end

        // Variable step
        cmd(0, 1, 4'd8, 0, 1, 4'd0);
        chk_w("ld8", 8, 0);
        cmd(0, 0, 4'd0, 1, 1, 4'd4);
        chk_w("up4", 2, 1);
        chk_s("up4", 9, 1);
        cmd(0, 0, 4'd0, 1, 0, 4'd3);
        chk_w("dn3", 9, 1);
        chk_s("dn3", 6, 0);
        cmd(0, 0, 4'd0, 1, 0, 4'd9);
        chk_w("dn9", 0, 0);
        chk_s("dn9", 0, 1);
        cmd(0, 0, 4'd0, 1, 1, 4'd0);
        chk_w("st0", 0, 0);
        chk_s("st0", 0, 0);
        cmd(0, 1, 4'd5, 0, 1, 4'd0);
        chk_w("ld5", 5, 0);
        cmd(0, 0, 4'd0, 1, 1, 4'd12);
        chk_w("up12", 4, 1);
        chk_s("up12", 9, 1);

        // Saturate scenario (wrap instance checked alongside)
        cmd(0, 1, 4'd7, 0, 1, 4'd0);
        chk_s("ld7", 7, 0);
        cmd(0, 0, 4'd0, 1, 1, 4'd5);
        chk_s("sup5a", 9, 1);
        check("sup5a_smax", int'(w_max_s), 1);
        chk_w("sup5a", 2, 1);
        cmd(0, 0, 4'd0, 1, 1, 4'd5);
        chk_s("sup5b", 9, 1);
        chk_w("sup5b", 7, 0);
        cmd(0, 0, 4'd0, 1, 0, 4'd9);
        chk_s("sdn9", 0, 0);
        chk_w("sdn9", 8, 1);
        cmd(0, 0, 4'd0, 1, 0, 4'd1);
        chk_s("sdn1", 0, 1);
        check("sdn1_smin", int'(w_min_s), 1);
        chk_w("sdn1", 7, 0);
        cmd(0, 0, 4'd0, 0, 1, 4'd1);
        chk_s("shold", 0, 0);
        chk_w("shold", 7, 0);

        // Priority
        cmd(1, 1, 4'd5, 1, 1, 4'd1);
        chk_w("clr", 0, 0);
        chk_s("clr", 0, 0);
        cmd(0, 0, 4'd0, 1, 1, 4'd12);
        chk_w("upmax", 9, 0);
        cmd(0, 0, 4'd0, 1, 1, 4'd1);
        chk_w("wrap9", 0, 1);
        chk_s("wrap9", 9, 1);
        cmd(0, 1, 4'd15, 1, 1, 4'd1);
        chk_w("ld15", 9, 0);
        chk_s("ld15", 9, 0);
        cmd(0, 1, 4'd3, 1, 1, 4'd2);
        chk_w("ld3en", 3, 0);
        chk_s("ld3en", 3, 0);

        // Asynchronous reset mid-count
        cmd(0, 1, 4'd5, 0, 1, 4'd1);
        cmd(0, 0, 4'd0, 1, 1, 4'd1);
        chk_w("pre_rst", 6, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_w("arst", 0, 0);
        chk_s("arst", 0, 0);
        check("arst_min", int'(w_min_w), 1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk_w("post_rst", 1, 0);
        chk_s("post_rst", 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
